// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU: opcodes, ALU control codes and the
// multicycle sequencer state encoding.
package cpu_pkg;

    localparam logic [6:0] OP_HALT   = 7'b0000000;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_J      = 7'b1101111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_ERROR     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for non-writing instructions: pc+imm when a
// jump or taken branch, else pc+4, with a word-misalignment flag on the result.
module pc_next_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_imm,
    input  logic              i_jump,
    input  logic              i_branch,
    input  logic              i_zero,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_misaligned
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic              w_take;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_rel;

    assign w_take       = i_jump | (i_branch & i_zero);
    assign w_seq        = i_pc + PC_STEP;
    assign w_rel        = i_pc + i_imm;
    assign o_target     = w_take ? w_rel : w_seq;
    assign o_misaligned = |o_target[1:0];

endmodule

// File: rtl/multicycle_sequencer.sv
// Fetch/decode/execute/writeback controller: owns the PC, the instruction
// fetch handshake with its wait timeout, and the IR / register-file strobes.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    output logic              ir_load,
    input  logic [6:0]        opcode,
    input  logic              reg_write_in,
    input  logic              branch_in,
    input  logic              jump_in,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] imm,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              timeout_err,
    output logic [31:0]       instr_count
);

    localparam logic [ADDR_W-1:0] PC_STEP      = ADDR_W'(4);
    // Last FETCH wait cycle: reaching it without ready ends in ERROR.
    localparam logic [7:0]        TIMEOUT_LAST = 8'(TIMEOUT - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       r_count;
    logic [31:0]       w_count_nxt;
    logic [7:0]        r_wait;
    logic [7:0]        w_wait_nxt;

    logic [ADDR_W-1:0] w_target;
    logic              w_misaligned;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .i_pc         (r_pc),
        .i_imm        (imm),
        .i_jump       (jump_in),
        .i_branch     (branch_in),
        .i_zero       (alu_zero),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        w_wait_nxt  = r_wait;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        rf_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wait_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load     = 1'b1;
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_DECODE;
                end else if (r_wait == TIMEOUT_LAST) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            ST_DECODE: begin
                w_state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (reg_write_in) begin
                    w_state_nxt = ST_WRITEBACK;
                end else if (w_misaligned) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_pc_nxt    = w_target;
                    w_count_nxt = r_count + 32'd1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                rf_we       = 1'b1;
                w_pc_nxt    = r_pc + PC_STEP;
                w_count_nxt = r_count + 32'd1;
                w_state_nxt = ST_FETCH;
            end
            default: begin
                // HALT and ERROR hold everything until reset.
            end
        endcase
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign state       = r_state;
    assign instr_count = r_count;
    assign halted      = (r_state == ST_HALT);
    assign timeout_err = (r_state == ST_ERROR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer with hand-computed
// expected values for each step.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        ir_load;
    logic [6:0]  opcode;
    logic        reg_write_in;
    logic        branch_in;
    logic        jump_in;
    logic        alu_zero;
    logic [31:0] imm;
    logic        rf_we;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        halted;
    logic        timeout_err;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .TIMEOUT  (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .ir_load      (ir_load),
        .opcode       (opcode),
        .reg_write_in (reg_write_in),
        .branch_in    (branch_in),
        .jump_in      (jump_in),
        .alu_zero     (alu_zero),
        .imm          (imm),
        .rf_we        (rf_we),
        .pc           (pc),
        .state        (state),
        .halted       (halted),
        .timeout_err  (timeout_err),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic rw, input logic br,
                             input logic jp, input logic z, input logic [31:0] im);
        opcode       = op;
        reg_write_in = rw;
        branch_in    = br;
        jump_in      = jp;
        alu_zero     = z;
        imm          = im;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0;
        set_instr(7'b0010011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_flags", {30'b0, halted, timeout_err}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("idle_state", {29'b0, state}, 32'd0);
        chk("idle_req", {31'b0, imem_req}, 32'd0);

        // ADDI, zero-wait memory
        pulse_start();
        chk("start_state", {29'b0, state}, 32'd1);
        chk("start_req", {31'b0, imem_req}, 32'd1);
        chk("start_addr", imem_addr, 32'h0);
        set_instr(7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        imem_ready = 1'b1;
        #1;
        chk("addi_irload", {31'b0, ir_load}, 32'd1);
        chk("addi_we_f", {31'b0, rf_we}, 32'd0);
        tick(); imem_ready = 1'b0;
        chk("addi_dec", {29'b0, state}, 32'd2);
        chk("addi_irload_d", {31'b0, ir_load}, 32'd0);
        chk("addi_we_d", {31'b0, rf_we}, 32'd0);
        tick();
        chk("addi_exe", {29'b0, state}, 32'd3);
        chk("addi_we_e", {31'b0, rf_we}, 32'd0);
        tick();
        chk("addi_wb", {29'b0, state}, 32'd4);
        chk("addi_we_wb", {31'b0, rf_we}, 32'd1);
        chk("addi_pc_wb", pc, 32'h0);
        tick();
        chk("addi_fetch", {29'b0, state}, 32'd1);
        chk("addi_we_after", {31'b0, rf_we}, 32'd0);
        chk("addi_pc", pc, 32'h4);
        chk("addi_cnt", instr_count, 32'd1);

        // Unrecognised opcode executes as NOP
        set_instr(7'b0001111, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        tick();
        chk("nop_we", {31'b0, rf_we}, 32'd0);
        tick();
        chk("nop_state", {29'b0, state}, 32'd1);
        chk("nop_pc", pc, 32'h8);
        chk("nop_cnt", instr_count, 32'd2);

        // Taken BEQ from pc=8, imm=-8
        set_instr(7'b1100011, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        chk("beq_we_d", {31'b0, rf_we}, 32'd0);
        tick();
        chk("beq_we_e", {31'b0, rf_we}, 32'd0);
        tick();
        chk("beq_pc", pc, 32'h0);
        chk("beq_cnt", instr_count, 32'd3);
        chk("beq_we_f", {31'b0, rf_we}, 32'd0);

        // Jump +8 back to pc=8
        set_instr(7'b1101111, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        tick(); tick();
        chk("jal_pc", pc, 32'h8);
        chk("jal_cnt", instr_count, 32'd4);

        // Not-taken BEQ
        set_instr(7'b1100011, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        tick(); tick();
        chk("bne_pc", pc, 32'hC);
        chk("bne_cnt", instr_count, 32'd5);

        // Three memory wait cycles
        set_instr(7'b0001111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("wait_state", {29'b0, state}, 32'd1);
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'hC);
            chk("wait_irload", {31'b0, ir_load}, 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        #1;
        chk("wait_req4", {31'b0, imem_req}, 32'd1);
        chk("wait_irload4", {31'b0, ir_load}, 32'd1);
        tick(); imem_ready = 1'b0;
        chk("wait_req_off", {31'b0, imem_req}, 32'd0);
        chk("wait_irload_off", {31'b0, ir_load}, 32'd0);
        chk("wait_dec", {29'b0, state}, 32'd2);
        tick(); tick();
        chk("wait_pc", pc, 32'h10);
        chk("wait_cnt", instr_count, 32'd6);

        // Misaligned jump target
        set_instr(7'b1101111, 1'b0, 1'b0, 1'b1, 1'b0, 32'h6);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        tick(); tick();
        chk("mis_state", {29'b0, state}, 32'd6);
        chk("mis_err", {31'b0, timeout_err}, 32'd1);
        chk("mis_pc", pc, 32'h10);
        chk("mis_cnt", instr_count, 32'd6);
        imem_ready = 1'b1; start = 1'b1;
        tick(); tick();
        imem_ready = 1'b0; start = 1'b0;
        chk("mis_sticky", {29'b0, state}, 32'd6);
        chk("mis_req", {31'b0, imem_req}, 32'd0);

        // HALT after one NOP
        do_reset();
        chk("rst2_state", {29'b0, state}, 32'd0);
        chk("rst2_pc", pc, 32'h0);
        pulse_start();
        set_instr(7'b0001111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        tick(); tick();
        set_instr(7'b0000000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        tick();
        chk("halt_state", {29'b0, state}, 32'd5);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            imem_ready = i[0];
            start = ~i[0];
            tick();
        end
        imem_ready = 1'b0; start = 1'b0;
        chk("halt_hold", {29'b0, state}, 32'd5);
        chk("halt_pc", pc, 32'h4);
        chk("halt_cnt", instr_count, 32'd1);
        chk("halt_we", {31'b0, rf_we}, 32'd0);

        // Ready arriving on the last allowed wait cycle wins over timeout
        do_reset();
        pulse_start();
        set_instr(7'b0001111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 14; i++) tick();
        chk("edge_state", {29'b0, state}, 32'd1);
        imem_ready = 1'b1;
        #1;
        chk("edge_irload", {31'b0, ir_load}, 32'd1);
        tick(); imem_ready = 1'b0;
        chk("edge_dec", {29'b0, state}, 32'd2);
        tick(); tick();
        chk("edge_pc", pc, 32'h4);
        chk("edge_cnt", instr_count, 32'd1);

        // Async reset between edges while requesting
        chk("arst_pre_req", {31'b0, imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_state", {29'b0, state}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_cnt", instr_count, 32'd0);
        tick();
        rst = 1'b0;

        // Fetch timeout
        tick();
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            chk("to_fetch", {29'b0, state}, 32'd1);
            tick();
        end
        chk("to_state", {29'b0, state}, 32'd6);
        chk("to_err", {31'b0, timeout_err}, 32'd1);
        chk("to_req", {31'b0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        tick(); tick(); tick();
        chk("to_sticky", {29'b0, state}, 32'd6);
        chk("to_err_sticky", {31'b0, timeout_err}, 32'd1);
        chk("to_irload", {31'b0, ir_load}, 32'd0);
        chk("to_pc", pc, 32'h0);
        imem_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback controller for the lab CPU datapath.
- Owns the PC register and the instruction-memory request handshake.
- Feeds the fetched opcode to the control unit and consumes its decoded reg_write/branch/jump strobes.
- Issues one-cycle load/write enables to the IR and register file, so the single-cycle datapath can share one memory port and run as a sequenced pipeline of phases.

Parameters:
ADDR_W, 32, PC / instruction address width
RESET_PC, 0, PC value after reset
TIMEOUT, 15, max FETCH wait cycles without imem_ready before ERROR (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin execution; sampled only in IDLE
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ready  in  1  fetch data valid this cycle
ir_load  out  1  load IR from memory data (one cycle)
opcode  in  7  IR[6:0], also routed to control unit
reg_write_in  in  1  from control unit
branch_in  in  1  from control unit
jump_in  in  1  from control unit
alu_zero  in  1  ALU zero flag, valid in EXECUTE
imm  in  ADDR_W  sign-extended byte offset from IR
rf_we  out  1  register-file write enable (one cycle)
pc  out  ADDR_W  current PC
state  out  3  current state encoding
halted  out  1  high in HALT
timeout_err  out  1  high in ERROR
instr_count  out  32  retired-instruction counter

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, instr_count=0. All strobes, halted and timeout_err are 0. imem_req drops in the same cycle rst asserts.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, ERROR=6.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH:
  - imem_req=1, imem_addr=pc. Request is held stable until imem_ready.
  - On imem_ready=1: ir_load=1 combinationally in that cycle -> DECODE; wait counter cleared.
  - Else the wait counter increments. When the counter reaches TIMEOUT -> ERROR.
  - If ready and timeout coincide, ready wins.
- DECODE (1 cycle):
  - opcode==7'b0000000 -> HALT.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle). The ALU result and alu_zero are valid here.
  - If reg_write_in=1 -> WRITEBACK; pc unchanged.
  - Else compute next pc:
    - jump_in=1 -> pc+imm
    - else branch_in=1 and alu_zero=1 -> pc+imm
    - else pc+4
  - Unrecognised opcodes decode to all-zero strobes and execute as NOP (pc+4).
  - If the target has bits[1:0]!=0 -> ERROR, pc not updated.
  - Otherwise pc<=target, instr_count+1, -> FETCH.
- WRITEBACK (1 cycle): rf_we=1, pc<=pc+4, instr_count+1, -> FETCH.
- HALT: halted=1; pc and instr_count are frozen. Exit only via rst.
- ERROR: timeout_err=1, sticky; pc frozen. Exit only via rst.
- Arithmetic: pc addition wraps modulo 2^ADDR_W; instr_count wraps modulo 2^32.
- imem_ready outside FETCH is ignored.
- Latency with zero-wait memory (imem_ready high in the first FETCH cycle):
  - register-writing instruction: 4 cycles/instr (FETCH, DECODE, EXECUTE, WRITEBACK)
  - branch/jump/NOP: 3 cycles/instr
  - each memory wait cycle adds 1.
- Outputs rf_we, ir_load and imem_req are decoded from the registered state (plus imem_ready for ir_load). There are no glitch-free requirements beyond that.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (R/I/S/B/J types, HALT=0) shared with the control unit
  - ALU control codes
  - the sequencer state encoding
- One natural sub-module: pc_next_calc. It is combinational and takes pc, imm, jump_in, branch_in and alu_zero. It outputs the target plus a misaligned flag.
- The sequencer keeps the FSM, the wait counter and the registers.

Test Plan:
- Reset/start: rst=1 then release; hold start=0 for 5 cycles -> state=0, pc=RESET_PC, imem_req=0. Then pulse start -> imem_req=1 with imem_addr=0 on the next cycle.
- ADDI with zero-wait memory: opcode=0010011, reg_write_in=1 -> rf_we pulses exactly once, 3 cycles after FETCH entry. pc 0->4, instr_count=1, next FETCH at cycle 4.
- Taken BEQ: pc=8, opcode=1100011, branch_in=1, alu_zero=1, imm=-8 -> pc=0 after EXECUTE, rf_we never asserted. Repeat with alu_zero=0 -> pc=12.
- Memory wait and timeout:
  - imem_ready delayed 3 cycles -> imem_req held 4 cycles, ir_load a single pulse.
  - No ready for TIMEOUT cycles -> state=6, timeout_err=1, stays after further imem_ready.
- Jump misaligned and HALT:
  - jump_in=1 with imm=6 -> ERROR, pc unchanged.
  - Separately, fetch opcode=0 -> halted=1, pc and instr_count frozen for 10 cycles.
- Async reset mid-FETCH: assert rst between clock edges while imem_req=1 -> imem_req=0 immediately, state=IDLE, pc=RESET_PC, instr_count=0.
